// File: rtl/ps2_kbd_ascii_fifo.sv
// ---------------------------------------------------------------------------
// ps2_kbd_ascii_fifo
//
// PS/2 scan-code set 2 keyboard decoder with an output character FIFO.
// Accepted bytes run through a prefix FSM that handles E0, F0 and E1. The
// FSM also tracks shift, ctrl and caps-lock. Make codes of mapped keys are
// turned into ASCII and pushed into a small FIFO in the same edge that
// accepts the byte.
//
// Optional feature macro: PS2_CTRL_CODES_EN
//   When it is defined and ctrl is held, a letter make outputs its control
//   code (a = 01 .. z = 1A), ignoring shift and caps. When it is undefined,
//   ctrl is still tracked but does not change the output.
//
// Parameters:
//   FIFO_DEPTH    character FIFO entries (power of two, >= 2)
//   CAPS_INIT     caps-lock state after reset
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   scan_valid    one-cycle strobe qualifying scan_code
//   scan_code     received PS/2 byte
//   ascii_data    FIFO head, meaningful only while ascii_valid
//   ascii_valid   FIFO non-empty
//   ascii_ready   consumer takes the head when ascii_valid & ascii_ready
//   fifo_count    current FIFO occupancy
//   overflow      sticky flag; set when a character is dropped on a full FIFO
//   overflow_clr  clears overflow on the next edge, unless a drop happens in
//                 that same edge
//   caps_led      current caps-lock state
//   shift_active  left or right shift held
// ---------------------------------------------------------------------------
module ps2_kbd_ascii_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter bit CAPS_INIT  = 1'b0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            scan_valid,
  input  logic [7:0]                      scan_code,
  output logic [7:0]                      ascii_data,
  output logic                            ascii_valid,
  input  logic                            ascii_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow,
  input  logic                            overflow_clr,
  output logic                            caps_led,
  output logic                            shift_active
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

`ifdef PS2_CTRL_CODES_EN
  localparam bit CTRL_CODES = 1'b1;
`else
  localparam bit CTRL_CODES = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_PAUSE   = 3'd4
  } state_t;

  // Base key map: {mapped, letter, unshifted, shifted}.
  function automatic logic [17:0] key_map(input logic [7:0] code);
    case (code)
      8'h1C: key_map = {2'b11, 8'h61, 8'h41};  // a
      8'h32: key_map = {2'b11, 8'h62, 8'h42};  // b
      8'h21: key_map = {2'b11, 8'h63, 8'h43};  // c
      8'h23: key_map = {2'b11, 8'h64, 8'h44};  // d
      8'h24: key_map = {2'b11, 8'h65, 8'h45};  // e
      8'h2B: key_map = {2'b11, 8'h66, 8'h46};  // f
      8'h34: key_map = {2'b11, 8'h67, 8'h47};  // g
      8'h33: key_map = {2'b11, 8'h68, 8'h48};  // h
      8'h43: key_map = {2'b11, 8'h69, 8'h49};  // i
      8'h3B: key_map = {2'b11, 8'h6A, 8'h4A};  // j
      8'h42: key_map = {2'b11, 8'h6B, 8'h4B};  // k
      8'h4B: key_map = {2'b11, 8'h6C, 8'h4C};  // l
      8'h3A: key_map = {2'b11, 8'h6D, 8'h4D};  // m
      8'h31: key_map = {2'b11, 8'h6E, 8'h4E};  // n
      8'h44: key_map = {2'b11, 8'h6F, 8'h4F};  // o
      8'h4D: key_map = {2'b11, 8'h70, 8'h50};  // p
      8'h15: key_map = {2'b11, 8'h71, 8'h51};  // q
      8'h2D: key_map = {2'b11, 8'h72, 8'h52};  // r
      8'h1B: key_map = {2'b11, 8'h73, 8'h53};  // s
      8'h2C: key_map = {2'b11, 8'h74, 8'h54};  // t
      8'h3C: key_map = {2'b11, 8'h75, 8'h55};  // u
      8'h2A: key_map = {2'b11, 8'h76, 8'h56};  // v
      8'h1D: key_map = {2'b11, 8'h77, 8'h57};  // w
      8'h22: key_map = {2'b11, 8'h78, 8'h58};  // x
      8'h35: key_map = {2'b11, 8'h79, 8'h59};  // y
      8'h1A: key_map = {2'b11, 8'h7A, 8'h5A};  // z
      8'h16: key_map = {2'b10, 8'h31, 8'h21};  // 1 !
      8'h1E: key_map = {2'b10, 8'h32, 8'h40};  // 2 @
      8'h26: key_map = {2'b10, 8'h33, 8'h23};  // 3 #
      8'h25: key_map = {2'b10, 8'h34, 8'h24};  // 4 $
      8'h2E: key_map = {2'b10, 8'h35, 8'h25};  // 5 %
      8'h36: key_map = {2'b10, 8'h36, 8'h5E};  // 6 ^
      8'h3D: key_map = {2'b10, 8'h37, 8'h26};  // 7 &
      8'h3E: key_map = {2'b10, 8'h38, 8'h2A};  // 8 *
      8'h46: key_map = {2'b10, 8'h39, 8'h28};  // 9 (
      8'h45: key_map = {2'b10, 8'h30, 8'h29};  // 0 )
      8'h0E: key_map = {2'b10, 8'h60, 8'h7E};  // ` ~
      8'h4E: key_map = {2'b10, 8'h2D, 8'h5F};  // - _
      8'h55: key_map = {2'b10, 8'h3D, 8'h2B};  // = +
      8'h54: key_map = {2'b10, 8'h5B, 8'h7B};  // [ {
      8'h5B: key_map = {2'b10, 8'h5D, 8'h7D};  // ] }
      8'h5D: key_map = {2'b10, 8'h5C, 8'h7C};  // \ |
      8'h4C: key_map = {2'b10, 8'h3B, 8'h3A};  // ; :
      8'h52: key_map = {2'b10, 8'h27, 8'h22};  // ' "
      8'h41: key_map = {2'b10, 8'h2C, 8'h3C};  // , <
      8'h49: key_map = {2'b10, 8'h2E, 8'h3E};  // . >
      8'h4A: key_map = {2'b10, 8'h2F, 8'h3F};  // / ?
      8'h29: key_map = {2'b10, 8'h20, 8'h20};  // space
      8'h0D: key_map = {2'b10, 8'h09, 8'h09};  // tab
      8'h5A: key_map = {2'b10, 8'h0D, 8'h0D};  // enter
      8'h66: key_map = {2'b10, 8'h08, 8'h08};  // backspace
      8'h76: key_map = {2'b10, 8'h1B, 8'h1B};  // esc
      default: key_map = 18'h00000;
    endcase
  endfunction

  // Extended (E0-prefixed) key map: {mapped, char}.
  function automatic logic [8:0] ext_map(input logic [7:0] code);
    case (code)
      8'h71:   ext_map = {1'b1, 8'h7F};  // delete
      8'h4A:   ext_map = {1'b1, 8'h2F};  // keypad /
      8'h5A:   ext_map = {1'b1, 8'h0D};  // keypad enter
      default: ext_map = 9'h000;
    endcase
  endfunction

  state_t         state;
  logic [2:0]     pause_cnt;
  logic           lshift, rshift, lctrl, rctrl, caps_held;
  logic           lshift_nxt, rshift_nxt, lctrl_nxt, rctrl_nxt;
  logic           caps_nxt, caps_held_nxt;
  logic           make_ev, ext_make_ev, brk_ev, ext_brk_ev;
  logic           push_req;
  logic [7:0]     push_char;
  logic [17:0]    kmap;
  logic [8:0]     emap;
  logic           ctrl_held;

  logic [7:0]     mem [0:FIFO_DEPTH-1];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count_nxt;
  logic           pop, full, do_push, drop;

  assign ctrl_held = lctrl | rctrl;

  // Classify the accepted byte against the current prefix state.
  always_comb begin
    make_ev     = 1'b0;
    ext_make_ev = 1'b0;
    brk_ev      = 1'b0;
    ext_brk_ev  = 1'b0;
    if (scan_valid) begin
      case (state)
        ST_IDLE: begin
          case (scan_code)
            8'hE0, 8'hF0, 8'hE1,
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF: make_ev = 1'b0;
            default:                                   make_ev = 1'b1;
          endcase
        end
        ST_EXT:     ext_make_ev = (scan_code != 8'hF0);
        ST_BRK:     brk_ev      = 1'b1;
        ST_EXT_BRK: ext_brk_ev  = 1'b1;
        default:    make_ev     = 1'b0;  // pause bytes are swallowed
      endcase
    end else begin
      make_ev = 1'b0;
    end
  end

  // Next modifier state; the character path below still sees the old values.
  always_comb begin
    lshift_nxt    = lshift;
    rshift_nxt    = rshift;
    lctrl_nxt     = lctrl;
    rctrl_nxt     = rctrl;
    caps_nxt      = caps_led;
    caps_held_nxt = caps_held;
    if (make_ev) begin
      case (scan_code)
        8'h12: lshift_nxt = 1'b1;
        8'h59: rshift_nxt = 1'b1;
        8'h14: lctrl_nxt  = 1'b1;
        8'h58: begin
          // Toggle only on the first make so typematic repeats are ignored.
          caps_nxt      = caps_held ? caps_led : ~caps_led;
          caps_held_nxt = 1'b1;
        end
        default: caps_held_nxt = caps_held;
      endcase
    end else if (brk_ev) begin
      case (scan_code)
        8'h12:   lshift_nxt    = 1'b0;
        8'h59:   rshift_nxt    = 1'b0;
        8'h14:   lctrl_nxt     = 1'b0;
        8'h58:   caps_held_nxt = 1'b0;
        default: caps_held_nxt = caps_held;
      endcase
    end else if (ext_make_ev) begin
      if (scan_code == 8'h14) begin
        rctrl_nxt = 1'b1;
      end else begin
        rctrl_nxt = rctrl;
      end
    end else if (ext_brk_ev) begin
      if (scan_code == 8'h14) begin
        rctrl_nxt = 1'b0;
      end else begin
        rctrl_nxt = rctrl;
      end
    end else begin
      rctrl_nxt = rctrl;
    end
  end

  // Translate a make code into the character to push, if any.
  always_comb begin
    kmap      = key_map(scan_code);
    emap      = ext_map(scan_code);
    push_req  = 1'b0;
    push_char = 8'h00;
    if (make_ev) begin
      push_req = kmap[17];
      if (kmap[16]) begin
        if (CTRL_CODES && ctrl_held) begin
          push_char = kmap[15:8] - 8'h60;
        end else if (shift_active ^ caps_led) begin
          push_char = kmap[7:0];
        end else begin
          push_char = kmap[15:8];
        end
      end else if (shift_active) begin
        push_char = kmap[7:0];
      end else begin
        push_char = kmap[15:8];
      end
    end else if (ext_make_ev) begin
      push_req  = emap[8];
      push_char = emap[7:0];
    end else begin
      push_req = 1'b0;
    end
  end

  // Prefix FSM, pause counter and registered modifier state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      pause_cnt    <= 3'd0;
      lshift       <= 1'b0;
      rshift       <= 1'b0;
      lctrl        <= 1'b0;
      rctrl        <= 1'b0;
      caps_held    <= 1'b0;
      caps_led     <= CAPS_INIT;
      shift_active <= 1'b0;
    end else begin
      lshift       <= lshift_nxt;
      rshift       <= rshift_nxt;
      lctrl        <= lctrl_nxt;
      rctrl        <= rctrl_nxt;
      caps_held    <= caps_held_nxt;
      caps_led     <= caps_nxt;
      shift_active <= lshift_nxt | rshift_nxt;
      if (scan_valid) begin
        case (state)
          ST_IDLE: begin
            case (scan_code)
              8'hE0: state <= ST_EXT;
              8'hF0: state <= ST_BRK;
              8'hE1: begin
                state     <= ST_PAUSE;
                pause_cnt <= 3'd0;
              end
              default: state <= ST_IDLE;
            endcase
          end
          ST_EXT: begin
            if (scan_code == 8'hF0) begin
              state <= ST_EXT_BRK;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_BRK:     state <= ST_IDLE;
          ST_EXT_BRK: state <= ST_IDLE;
          ST_PAUSE: begin
            // Seven bytes follow E1 in the pause sequence: counts 0..6.
            if (pause_cnt == 3'd6) begin
              state <= ST_IDLE;
            end else begin
              pause_cnt <= pause_cnt + 3'd1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // FIFO handshake; a pop frees the slot a same-edge push needs when full.
  always_comb begin
    pop     = ascii_valid & ascii_ready;
    full    = (fifo_count == CW'(FIFO_DEPTH));
    do_push = push_req & (~full | pop);
    drop    = push_req & full & ~pop;
    if (do_push && !pop) begin
      count_nxt = fifo_count + CW'(1);
    end else if (pop && !do_push) begin
      count_nxt = fifo_count - CW'(1);
    end else begin
      count_nxt = fifo_count;
    end
  end

  // FIFO pointers, occupancy, valid and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= {AW{1'b0}};
      rd_ptr      <= {AW{1'b0}};
      fifo_count  <= {CW{1'b0}};
      ascii_valid <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      fifo_count  <= count_nxt;
      ascii_valid <= (count_nxt != {CW{1'b0}});
      if (drop) begin
        overflow <= 1'b1;
      end else if (overflow_clr) begin
        overflow <= 1'b0;
      end
    end
  end

  // Character storage; contents are dropped logically by the pointer reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_char;
    end
  end

  assign ascii_data = mem[rd_ptr];

endmodule

// File: tb/tb_ps2_kbd_ascii_fifo.sv
// ---------------------------------------------------------------------------
// Self-checking bench for ps2_kbd_ascii_fifo. A behavioural keyboard model
// (prefix flags, modifier bits, lookup tables and a queue) predicts every
// output on every cycle. Hand-written sequences pin the model with literal
// expectations, and randomized traffic exercises the rest.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_ascii_fifo;

  localparam int DEPTH = 8;
`ifdef PS2_CTRL_CODES_EN
  localparam bit CTRL_EN = 1'b1;
`else
  localparam bit CTRL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scan_valid = 1'b0;
  logic [7:0] scan_code = 8'h00;
  logic [7:0] ascii_data;
  logic       ascii_valid;
  logic       ascii_ready = 1'b0;
  logic [3:0] fifo_count;
  logic       overflow;
  logic       overflow_clr = 1'b0;
  logic       caps_led;
  logic       shift_active;

  always #5 clk = ~clk;

  ps2_kbd_ascii_fifo #(.FIFO_DEPTH(DEPTH), .CAPS_INIT(1'b0)) dut (
    .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_code(scan_code),
    .ascii_data(ascii_data), .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
    .fifo_count(fifo_count), .overflow(overflow), .overflow_clr(overflow_clr),
    .caps_led(caps_led), .shift_active(shift_active)
  );

  int npass = 0;
  int ntotal = 0;

  // Lookup tables built from the US layout rows.
  logic [7:0] lo_map [256];
  logic [7:0] hi_map [256];
  bit         has_map [256];
  logic [7:0] mapped_q [$];
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
    8'h3E, 8'h46, 8'h45};
  logic [7:0] punct_codes [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C,
    8'h52, 8'h41, 8'h49, 8'h4A};
  logic [7:0] punct_lo [11] = '{8'h60, 8'h2D, 8'h3D, 8'h5B, 8'h5D, 8'h5C, 8'h3B,
    8'h27, 8'h2C, 8'h2E, 8'h2F};
  logic [7:0] punct_hi [11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A,
    8'h22, 8'h3C, 8'h3E, 8'h3F};
  logic [7:0] ctl_codes [5] = '{8'h29, 8'h0D, 8'h5A, 8'h66, 8'h76};
  logic [7:0] ctl_chars [5] = '{8'h20, 8'h09, 8'h0D, 8'h08, 8'h1B};

  // Behavioural model state.
  bit         m_ext, m_brk;
  int         m_pause;
  bit         m_lsh, m_rsh, m_lct, m_rct, m_caps, m_caps_held, m_ovf;
  logic [7:0] mq [$];
  logic [7:0] got [$];
  logic [7:0] exp_q [$];

  task automatic add_key(input logic [7:0] code, input logic [7:0] lo, input logic [7:0] hi);
    lo_map[code] = lo;
    hi_map[code] = hi;
    has_map[code] = 1'b1;
    mapped_q.push_back(code);
  endtask

  task automatic build_maps();
    string letters = "abcdefghijklmnopqrstuvwxyz";
    string digits  = "1234567890";
    string dshift  = "!@#$%^&*()";
    for (int i = 0; i < 256; i++) has_map[i] = 1'b0;
    for (int i = 0; i < 26; i++) add_key(letter_codes[i], letters[i], letters[i] - 8'd32);
    for (int i = 0; i < 10; i++) add_key(digit_codes[i], digits[i], dshift[i]);
    for (int i = 0; i < 11; i++) add_key(punct_codes[i], punct_lo[i], punct_hi[i]);
    for (int i = 0; i < 5; i++) add_key(ctl_codes[i], ctl_chars[i], ctl_chars[i]);
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_pause = 0;
    m_lsh = 0; m_rsh = 0; m_lct = 0; m_rct = 0;
    m_caps = 0; m_caps_held = 0; m_ovf = 0;
    mq.delete();
  endtask

  task automatic model_make(input logic [7:0] b, input bit ext, output int ch);
    bit sh = m_lsh | m_rsh;
    bit ct = m_lct | m_rct;
    ch = -1;
    if (ext) begin
      if (b == 8'h71) ch = 8'h7F;
      else if (b == 8'h4A) ch = 8'h2F;
      else if (b == 8'h5A) ch = 8'h0D;
      if (b == 8'h14) m_rct = 1;
    end else begin
      if (has_map[b]) begin
        if (lo_map[b] >= 8'h61 && lo_map[b] <= 8'h7A) begin
          ch = (sh ^ m_caps) ? hi_map[b] : lo_map[b];
          if (CTRL_EN && ct) ch = lo_map[b] - 8'h60;
        end else begin
          ch = sh ? hi_map[b] : lo_map[b];
        end
      end
      if (b == 8'h12) m_lsh = 1;
      if (b == 8'h59) m_rsh = 1;
      if (b == 8'h14) m_lct = 1;
      if (b == 8'h58) begin
        if (!m_caps_held) m_caps = !m_caps;
        m_caps_held = 1;
      end
    end
  endtask

  task automatic model_break(input logic [7:0] b, input bit ext);
    if (ext) begin
      if (b == 8'h14) m_rct = 0;
    end else begin
      if (b == 8'h12) m_lsh = 0;
      if (b == 8'h59) m_rsh = 0;
      if (b == 8'h14) m_lct = 0;
      if (b == 8'h58) m_caps_held = 0;
    end
  endtask

  task automatic model_byte(input logic [7:0] b, output int ch);
    ch = -1;
    if (m_pause > 0) begin
      m_pause--;
    end else if (!m_ext && !m_brk) begin
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_brk = 1;
      else if (b == 8'hE1) m_pause = 7;
      else if (!(b inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) model_make(b, 0, ch);
    end else if (!m_brk) begin
      if (b == 8'hF0) m_brk = 1;
      else begin
        model_make(b, 1, ch);
        m_ext = 0;
      end
    end else begin
      model_break(b, m_ext);
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  task automatic model_cycle(input logic v, input logic [7:0] c, input logic r, input logic clr);
    int ch = -1;
    bit pop = (mq.size() != 0) && r;
    if (v) model_byte(c, ch);
    if (pop) void'(mq.pop_front());
    if (clr) m_ovf = 0;
    if (ch >= 0) begin
      if (mq.size() < DEPTH) mq.push_back(ch[7:0]);
      else m_ovf = 1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    ntotal++;
    if (act == exp) npass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic check_all();
    chk("valid", ascii_valid, (mq.size() != 0) ? 1 : 0);
    if (mq.size() != 0) chk("data", ascii_data, mq[0]);
    chk("count", fifo_count, mq.size());
    chk("overflow", overflow, m_ovf);
    chk("caps_led", caps_led, m_caps);
    chk("shift_active", shift_active, m_lsh | m_rsh);
  endtask

  // One clock: drive at negedge, log consumption, step model, compare after edge.
  task automatic cycle(input logic v, input logic [7:0] c, input logic r, input logic clr);
    @(negedge clk);
    scan_valid = v; scan_code = c; ascii_ready = r; overflow_clr = clr;
    if (ascii_valid && r) got.push_back(ascii_data);
    model_cycle(v, c, r, clr);
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; scan_valid = 1'b0; ascii_ready = 1'b0; overflow_clr = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic send(input logic [7:0] c, input logic r);
    cycle(1'b1, c, r, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && ascii_valid; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drain_empty", fifo_count, 0);
  endtask

  task automatic check_seq(input string name);
    chk({name, "_len"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++) chk(name, got[i], exp_q[i]);
    got.delete();
    exp_q.delete();
  endtask

  function automatic logic [7:0] pick();
    int r = $urandom_range(0, 99);
    logic [7:0] mods [4] = '{8'h12, 8'h59, 8'h14, 8'h58};
    logic [7:0] exts [3] = '{8'h71, 8'h4A, 8'h5A};
    if (r < 8) return 8'hE0;
    if (r < 18) return 8'hF0;
    if (r < 19) return 8'hE1;
    if (r < 27) return mods[$urandom_range(0, 3)];
    if (r < 80) return mapped_q[$urandom_range(0, mapped_q.size() - 1)];
    if (r < 86) return exts[$urandom_range(0, 2)];
    return 8'($urandom_range(0, 255));
  endfunction

  int pct [6] = '{90, 20, 70, 5, 50, 100};

  initial begin
    build_maps();
    do_reset();
    chk("reset_count", fifo_count, 0);
    chk("reset_valid", ascii_valid, 0);
    chk("reset_overflow", overflow, 0);
    chk("reset_caps", caps_led, 0);
    chk("reset_shift", shift_active, 0);

    // Make then break of 'a'.
    send(8'h1C, 1'b1); send(8'hF0, 1'b1); send(8'h1C, 1'b1);
    drain();
    exp_q.push_back(8'h61);
    check_seq("seq_a");

    // Shift applies only while held.
    send(8'h12, 1'b1);
    chk("shift_on", shift_active, 1);
    send(8'h1C, 1'b1); send(8'hF0, 1'b1); send(8'h12, 1'b1);
    chk("shift_off", shift_active, 0);
    send(8'h1C, 1'b1);
    drain();
    exp_q.push_back(8'h41); exp_q.push_back(8'h61);
    check_seq("seq_shift");

    // Caps toggles once per press; shift XOR caps picks the case.
    send(8'h58, 1'b1);
    chk("caps_on", caps_led, 1);
    send(8'h58, 1'b1);
    chk("caps_repeat", caps_led, 1);
    send(8'hF0, 1'b1); send(8'h58, 1'b1); send(8'h1C, 1'b1);
    send(8'h12, 1'b1); send(8'h1C, 1'b1); send(8'hF0, 1'b1); send(8'h12, 1'b1);
    drain();
    exp_q.push_back(8'h41); exp_q.push_back(8'h61);
    check_seq("seq_caps");
    send(8'h58, 1'b1); send(8'hF0, 1'b1); send(8'h58, 1'b1);
    chk("caps_off", caps_led, 0);

    // Extended delete, extended break, pause sequence, then '1'.
    send(8'hE0, 1'b1); send(8'h71, 1'b1);
    send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h71, 1'b1);
    send(8'hE1, 1'b1); send(8'h14, 1'b1); send(8'h77, 1'b1); send(8'hE1, 1'b1);
    send(8'hF0, 1'b1); send(8'h14, 1'b1); send(8'hF0, 1'b1); send(8'h77, 1'b1);
    send(8'h16, 1'b1);
    drain();
    exp_q.push_back(8'h7F); exp_q.push_back(8'h31);
    check_seq("seq_ext_pause");

    // Overflow: ten letters into an eight-entry FIFO with no consumer.
    for (int i = 0; i < 10; i++) send(letter_codes[i], 1'b0);
    chk("full_count", fifo_count, 8);
    chk("overflow_set", overflow, 1);
    drain();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h61 + 8'(i));
    check_seq("seq_overflow");
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("overflow_clr", overflow, 0);

    // Push and pop together while full: no drop, count unchanged.
    for (int i = 0; i < 8; i++) send(letter_codes[i], 1'b0);
    send(8'h1C, 1'b1);
    chk("full_pushpop_count", fifo_count, 8);
    chk("full_pushpop_ovf", overflow, 0);
    drain();
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h61 + 8'(i));
    exp_q.push_back(8'h61);
    check_seq("seq_full_pushpop");

    // Ctrl with 'c'.
    send(8'h14, 1'b1); send(8'h21, 1'b1); send(8'hF0, 1'b1); send(8'h14, 1'b1);
    send(8'h21, 1'b1);
    drain();
    exp_q.push_back(CTRL_EN ? 8'h03 : 8'h63); exp_q.push_back(8'h63);
    check_seq("seq_ctrl");

    // Reset after E0 drops the prefix and FIFO contents.
    send(8'h1C, 1'b0); send(8'hE0, 1'b0);
    do_reset();
    chk("midreset_count", fifo_count, 0);
    chk("midreset_valid", ascii_valid, 0);
    send(8'h1C, 1'b0);
    chk("postreset_count", fifo_count, 1);
    chk("postreset_data", ascii_data, 8'h61);
    drain();
    got.delete();

    // Randomized traffic with varying consumer pressure.
    for (int blk = 0; blk < 6; blk++) begin
      for (int n = 0; n < 500; n++) begin
        cycle($urandom_range(0, 1) == 1, pick(),
              $urandom_range(0, 99) < pct[blk], $urandom_range(0, 99) < 4);
      end
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
